// File: rtl/maze_generator.sv
// Binary-tree perfect-maze generator driven by a 16-bit Galois LFSR.
// Produces maze[y][x] (1 = wall) with the entrance in row 0 and the exit in row size-1.
module maze_generator #(
  parameter int size = 9,
  parameter int N    = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [15:0]                 i_seed,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [size-1:0][size-1:0]   o_maze
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_CARVE = 3'd2,
    S_OPEN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int             C         = (size - 1) / 2;
  localparam logic [N-1:0]   CMAX      = N'(C - 1);
  localparam logic [N-1:0]   LAST_ROW  = N'(size - 1);
  localparam logic [15:0]    LFSR_INIT = 16'hACE1;
  localparam logic [15:0]    LFSR_TAPS = 16'hB400;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [size-1:0][size-1:0]   r_maze;
  logic [15:0]                 r_lfsr;
  logic [N-1:0]                r_row;
  logic [N-1:0]                r_cx;
  logic [N-1:0]                r_cy;
  logic                        r_busy;
  logic                        r_done;
  logic [N-1:0]                w_x;
  logic [N-1:0]                w_y;
  logic                        w_last_cell;

  assign w_x         = N'({r_cx, 1'b1});
  assign w_y         = N'({r_cy, 1'b1});
  assign w_last_cell = (r_cx == CMAX) && (r_cy == CMAX);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) w_state_nxt = S_CLEAR;
        else         w_state_nxt = r_state;
      end
      S_CLEAR: begin
        if (r_row == LAST_ROW) w_state_nxt = S_CARVE;
        else                   w_state_nxt = S_CLEAR;
      end
      S_CARVE: begin
        if (w_last_cell) w_state_nxt = S_OPEN;
        else             w_state_nxt = S_CARVE;
      end
      S_OPEN:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_maze  <= '1;
      r_lfsr  <= LFSR_INIT;
      r_row   <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_CARVE) || (w_state_nxt == S_OPEN);
      r_done  <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: begin
          // A zero seed would lock the LFSR, so it falls back to the reset value.
          if (i_start) r_lfsr <= (i_seed == 16'h0000) ? LFSR_INIT : i_seed;
        end
        S_CLEAR: begin
          r_maze[r_row] <= '1;
          r_row         <= (r_row == LAST_ROW) ? '0 : r_row + N'(1);
        end
        S_CARVE: begin
          r_maze[w_y][w_x] <= 1'b0;
          if ((r_cy == '0) && (r_cx == CMAX)) begin
            r_maze[w_y][w_x] <= 1'b0;
          end else if (r_cy == '0) begin
            r_maze[w_y][w_x + N'(1)] <= 1'b0;
          end else if ((r_cx == CMAX) || r_lfsr[0]) begin
            r_maze[w_y - N'(1)][w_x] <= 1'b0;
          end else begin
            r_maze[w_y][w_x + N'(1)] <= 1'b0;
          end
          r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
          if (r_cx == CMAX) begin
            r_cx <= '0;
            r_cy <= (r_cy == CMAX) ? '0 : r_cy + N'(1);
          end else begin
            r_cx <= r_cx + N'(1);
          end
        end
        S_OPEN: begin
          r_maze[0][1]           <= 1'b0;
          r_maze[size-1][size-2] <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_maze = r_maze;

endmodule
